// File: rtl/msrv32_pkg.sv
// Shared types and constants for the msrv32 data-memory access path.
package msrv32_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ADDR  = 2'b01,
        DATA  = 2'b10,
        MISAL = 2'b11
    } dmem_state_t;

    localparam logic [1:0] LS_BYTE = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_WORD = 2'b10;

    // Size 2'b11 falls into the word branch, so it is checked exactly like a word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic result;
        case (size)
            LS_BYTE: result = 1'b0;
            LS_HALF: result = offset[0];
            default: result = (offset != 2'b00);
        endcase
        return result;
    endfunction

endpackage

// File: rtl/msrv32_store_unit.sv
// Combinational store formatter: byte-lane mask and lane-replicated write data
// for a store of the given size at the given word offset.
module msrv32_store_unit
    import msrv32_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    output logic [3:0]  mask,
    output logic [31:0] data
);

    always_comb begin
        mask = 4'b1111;
        data = wdata;
        case (size)
            LS_BYTE: begin
                mask = 4'b0001 << offset;
                data = {4{wdata[7:0]}};
            end
            LS_HALF: begin
                mask = 4'b0011 << {offset[1], 1'b0};
                data = {2{wdata[15:0]}};
            end
            default: begin
                mask = 4'b1111;
                data = wdata;
            end
        endcase
    end

endmodule

// File: rtl/msrv32_dmem_ctrl.sv
// Data-memory access sequencer: accepts one load/store at a time, checks alignment,
// and runs a two-phase AHB-Lite style transfer with wait states.
module msrv32_dmem_ctrl
    import msrv32_pkg::*;
(
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        req_valid_in,
    output logic        req_ready_out,
    input  logic        req_we_in,
    input  logic [31:0] req_addr_in,
    input  logic [31:0] req_wdata_in,
    input  logic [1:0]  req_size_in,
    input  logic        req_unsigned_in,
    output logic [31:0] ms_riscv32_mp_dmaddr_out,
    output logic        ms_riscv32_mp_dmtrans_out,
    output logic        ms_riscv32_mp_dmwr_req_out,
    output logic [3:0]  ms_riscv32_mp_dmwr_mask_out,
    output logic [31:0] ms_riscv32_mp_dmdata_out,
    input  logic        ms_riscv32_mp_hready_in,
    input  logic        ahb_resp_in,
    output logic [1:0]  lu_offset_out,
    output logic [1:0]  lu_size_out,
    output logic        lu_unsigned_out,
    output logic        rsp_valid_out,
    output logic        rsp_err_out,
    output logic        misaligned_out,
    output logic        stall_out
);

    dmem_state_t state;
    dmem_state_t next_state;

    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        unsigned_q;

    logic        accept;
    logic [3:0]  store_mask;
    logic [31:0] store_data;

    assign accept = (state == IDLE) && req_valid_in;

    msrv32_store_unit u_store_unit (
        .size   (size_q),
        .offset (addr_q[1:0]),
        .wdata  (wdata_q),
        .mask   (store_mask),
        .data   (store_data)
    );

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Request fields stay frozen from accept until the next accept so the load unit sees stable values.
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
        end else if (accept) begin
            we_q       <= req_we_in;
            addr_q     <= req_addr_in;
            wdata_q    <= req_wdata_in;
            size_q     <= req_size_in;
            unsigned_q <= req_unsigned_in;
        end
    end

    always_comb begin
        next_state                  = state;
        req_ready_out               = 1'b0;
        ms_riscv32_mp_dmaddr_out    = 32'd0;
        ms_riscv32_mp_dmtrans_out   = 1'b0;
        ms_riscv32_mp_dmwr_req_out  = 1'b0;
        ms_riscv32_mp_dmwr_mask_out = 4'b0000;
        ms_riscv32_mp_dmdata_out    = 32'd0;
        rsp_valid_out               = 1'b0;
        rsp_err_out                 = 1'b0;
        misaligned_out              = 1'b0;
        case (state)
            IDLE: begin
                req_ready_out = 1'b1;
                if (req_valid_in) begin
                    next_state = is_misaligned(req_size_in, req_addr_in[1:0]) ? MISAL : ADDR;
                end
            end
            ADDR: begin
                ms_riscv32_mp_dmtrans_out  = 1'b1;
                ms_riscv32_mp_dmaddr_out   = {addr_q[31:2], 2'b00};
                ms_riscv32_mp_dmwr_req_out = we_q;
                if (ms_riscv32_mp_hready_in) begin
                    next_state = DATA;
                end
            end
            DATA: begin
                if (we_q) begin
                    ms_riscv32_mp_dmwr_mask_out = store_mask;
                    ms_riscv32_mp_dmdata_out    = store_data;
                end
                if (ms_riscv32_mp_hready_in) begin
                    rsp_valid_out = 1'b1;
                    rsp_err_out   = ahb_resp_in;
                    next_state    = IDLE;
                end
            end
            MISAL: begin
                rsp_valid_out  = 1'b1;
                misaligned_out = 1'b1;
                next_state     = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign stall_out       = (state != IDLE) && !rsp_valid_out;
    assign lu_offset_out   = addr_q[1:0];
    assign lu_size_out     = size_q;
    assign lu_unsigned_out = unsigned_q;

endmodule

// File: tb/tb_msrv32_dmem_ctrl.sv
// Directed self-checking bench for msrv32_dmem_ctrl: inputs change 1 ns after the
// rising edge, outputs are sampled at the falling edge.
module tb_msrv32_dmem_ctrl;

    logic        clock;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] dmaddr;
    logic        dmtrans;
    logic        dmwr_req;
    logic [3:0]  dmwr_mask;
    logic [31:0] dmdata;
    logic        hready;
    logic        ahb_resp;
    logic [1:0]  lu_offset;
    logic [1:0]  lu_size;
    logic        lu_unsigned;
    logic        rsp_valid;
    logic        rsp_err;
    logic        misaligned;
    logic        stall;

    int checkCount;
    int errorCount;

    msrv32_dmem_ctrl dut (
        .ms_riscv32_mp_clk_in        (clock),
        .ms_riscv32_mp_rst_in        (rst_n),
        .req_valid_in                (req_valid),
        .req_ready_out               (req_ready),
        .req_we_in                   (req_we),
        .req_addr_in                 (req_addr),
        .req_wdata_in                (req_wdata),
        .req_size_in                 (req_size),
        .req_unsigned_in             (req_unsigned),
        .ms_riscv32_mp_dmaddr_out    (dmaddr),
        .ms_riscv32_mp_dmtrans_out   (dmtrans),
        .ms_riscv32_mp_dmwr_req_out  (dmwr_req),
        .ms_riscv32_mp_dmwr_mask_out (dmwr_mask),
        .ms_riscv32_mp_dmdata_out    (dmdata),
        .ms_riscv32_mp_hready_in     (hready),
        .ahb_resp_in                 (ahb_resp),
        .lu_offset_out               (lu_offset),
        .lu_size_out                 (lu_size),
        .lu_unsigned_out             (lu_unsigned),
        .rsp_valid_out               (rsp_valid),
        .rsp_err_out                 (rsp_err),
        .misaligned_out              (misaligned),
        .stall_out                   (stall)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] simulation timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [1:0] size,
                                 input logic uns, input logic rdy, input logic resp);
        req_valid    = valid;
        req_we       = we;
        req_addr     = addr;
        req_wdata    = wdata;
        req_size     = size;
        req_unsigned = uns;
        hready       = rdy;
        ahb_resp     = resp;
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idleBus(input logic rdy);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0, rdy, 1'b0);
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        rst_n = 1'b0;
        idleBus(1'b1);
        #23;

        checkOutput("rst_ready",   {31'd0, req_ready}, 32'd1);
        checkOutput("rst_trans",   {31'd0, dmtrans},   32'd0);
        checkOutput("rst_dmaddr",  dmaddr,             32'd0);
        checkOutput("rst_rsp",     {31'd0, rsp_valid}, 32'd0);
        checkOutput("rst_stall",   {31'd0, stall},     32'd0);
        checkOutput("rst_lu",      {27'd0, lu_offset, lu_size, lu_unsigned}, 32'd0);
        rst_n = 1'b1;

        // Aligned word load, no wait states
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h1000_0004, 32'd0, 2'b10, 1'b0, 1'b1, 1'b0);
        #4;
        checkOutput("t1_c0_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("t1_c0_stall", {31'd0, stall},     32'd0);
        nextCycle();
        idleBus(1'b1);
        #4;
        checkOutput("t1_c1_trans",  {31'd0, dmtrans},  32'd1);
        checkOutput("t1_c1_dmaddr", dmaddr,            32'h1000_0004);
        checkOutput("t1_c1_wr",     {31'd0, dmwr_req}, 32'd0);
        checkOutput("t1_c1_stall",  {31'd0, stall},    32'd1);
        checkOutput("t1_c1_ready",  {31'd0, req_ready}, 32'd0);
        checkOutput("t1_c1_rsp",    {31'd0, rsp_valid}, 32'd0);
        nextCycle();
        #4;
        checkOutput("t1_c2_rsp",    {31'd0, rsp_valid}, 32'd1);
        checkOutput("t1_c2_err",    {31'd0, rsp_err},   32'd0);
        checkOutput("t1_c2_stall",  {31'd0, stall},     32'd0);
        checkOutput("t1_c2_ready",  {31'd0, req_ready}, 32'd0);
        checkOutput("t1_c2_trans",  {31'd0, dmtrans},   32'd0);
        checkOutput("t1_c2_mask",   {28'd0, dmwr_mask}, 32'd0);
        checkOutput("t1_c2_lusize", {30'd0, lu_size},   32'd2);
        checkOutput("t1_c2_luoff",  {30'd0, lu_offset}, 32'd0);
        nextCycle();
        #4;
        checkOutput("t1_c3_ready",  {31'd0, req_ready}, 32'd1);
        checkOutput("t1_c3_rsp",    {31'd0, rsp_valid}, 32'd0);

        // Byte store at offset 3
        nextCycle();
        applyStimulus(1'b1, 1'b1, 32'h2000_0003, 32'h0000_00A5, 2'b00, 1'b0, 1'b1, 1'b0);
        nextCycle();
        idleBus(1'b1);
        #4;
        checkOutput("t2_c1_dmaddr", dmaddr,             32'h2000_0000);
        checkOutput("t2_c1_wr",     {31'd0, dmwr_req},  32'd1);
        checkOutput("t2_c1_mask",   {28'd0, dmwr_mask}, 32'd0);
        nextCycle();
        #4;
        checkOutput("t2_c2_mask",   {28'd0, dmwr_mask}, 32'b1000);
        checkOutput("t2_c2_data",   dmdata,             32'hA5A5_A5A5);
        checkOutput("t2_c2_rsp",    {31'd0, rsp_valid}, 32'd1);
        checkOutput("t2_c2_trans",  {31'd0, dmtrans},   32'd0);
        nextCycle();
        #4;
        checkOutput("t2_c3_mask",   {28'd0, dmwr_mask}, 32'd0);

        // Unsigned half load at offset 2 with two data-phase wait states
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h3000_0002, 32'd0, 2'b01, 1'b1, 1'b1, 1'b0);
        nextCycle();
        idleBus(1'b1);
        #4;
        checkOutput("t3_c1_trans", {31'd0, dmtrans}, 32'd1);
        checkOutput("t3_c1_dmaddr", dmaddr, 32'h3000_0000);
        for (int i = 2; i <= 3; i++) begin
            nextCycle();
            idleBus(1'b0);
            #4;
            checkOutput($sformatf("t3_c%0d_rsp", i),   {31'd0, rsp_valid},   32'd0);
            checkOutput($sformatf("t3_c%0d_stall", i), {31'd0, stall},       32'd1);
            checkOutput($sformatf("t3_c%0d_luoff", i), {30'd0, lu_offset},   32'd2);
            checkOutput($sformatf("t3_c%0d_luuns", i), {31'd0, lu_unsigned}, 32'd1);
        end
        nextCycle();
        idleBus(1'b1);
        #4;
        checkOutput("t3_c4_rsp",    {31'd0, rsp_valid},   32'd1);
        checkOutput("t3_c4_stall",  {31'd0, stall},       32'd0);
        checkOutput("t3_c4_luoff",  {30'd0, lu_offset},   32'd2);
        checkOutput("t3_c4_luuns",  {31'd0, lu_unsigned}, 32'd1);
        checkOutput("t3_c4_lusize", {30'd0, lu_size},     32'd1);
        nextCycle();
        #4;
        checkOutput("t3_c5_rsp",    {31'd0, rsp_valid},   32'd0);
        checkOutput("t3_c5_luoff",  {30'd0, lu_offset},   32'd2);

        // Half store at offset 2 with one address-phase wait state
        nextCycle();
        applyStimulus(1'b1, 1'b1, 32'h5000_0006, 32'hFFFF_1234, 2'b01, 1'b0, 1'b0, 1'b0);
        nextCycle();
        idleBus(1'b0);
        #4;
        checkOutput("t4_c1_trans",  {31'd0, dmtrans}, 32'd1);
        checkOutput("t4_c1_dmaddr", dmaddr,           32'h5000_0004);
        nextCycle();
        idleBus(1'b1);
        #4;
        checkOutput("t4_c2_trans",  {31'd0, dmtrans},  32'd1);
        checkOutput("t4_c2_dmaddr", dmaddr,            32'h5000_0004);
        checkOutput("t4_c2_wr",     {31'd0, dmwr_req}, 32'd1);
        checkOutput("t4_c2_stall",  {31'd0, stall},    32'd1);
        nextCycle();
        #4;
        checkOutput("t4_c3_mask",   {28'd0, dmwr_mask}, 32'b1100);
        checkOutput("t4_c3_data",   dmdata,             32'h1234_1234);
        checkOutput("t4_c3_rsp",    {31'd0, rsp_valid}, 32'd1);

        // Word store using size 11 behaves as a word
        nextCycle();
        applyStimulus(1'b1, 1'b1, 32'h6000_0008, 32'hDEAD_BEEF, 2'b11, 1'b0, 1'b1, 1'b0);
        nextCycle();
        idleBus(1'b1);
        nextCycle();
        #4;
        checkOutput("t5_mask", {28'd0, dmwr_mask}, 32'b1111);
        checkOutput("t5_data", dmdata,             32'hDEAD_BEEF);
        checkOutput("t5_rsp",  {31'd0, rsp_valid}, 32'd1);

        // Misaligned word load
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h4000_0001, 32'd0, 2'b10, 1'b0, 1'b1, 1'b0);
        #4;
        checkOutput("t6_c0_trans", {31'd0, dmtrans}, 32'd0);
        nextCycle();
        idleBus(1'b1);
        #4;
        checkOutput("t6_c1_trans", {31'd0, dmtrans},    32'd0);
        checkOutput("t6_c1_mis",   {31'd0, misaligned}, 32'd1);
        checkOutput("t6_c1_rsp",   {31'd0, rsp_valid},  32'd1);
        checkOutput("t6_c1_err",   {31'd0, rsp_err},    32'd0);
        checkOutput("t6_c1_stall", {31'd0, stall},      32'd0);
        nextCycle();
        #4;
        checkOutput("t6_c2_ready", {31'd0, req_ready},  32'd1);
        checkOutput("t6_c2_trans", {31'd0, dmtrans},    32'd0);
        checkOutput("t6_c2_mis",   {31'd0, misaligned}, 32'd0);

        // Misaligned half store at offset 3
        nextCycle();
        applyStimulus(1'b1, 1'b1, 32'h4000_0003, 32'h0000_BEEF, 2'b01, 1'b0, 1'b1, 1'b0);
        nextCycle();
        idleBus(1'b1);
        #4;
        checkOutput("t7_mis",   {31'd0, misaligned}, 32'd1);
        checkOutput("t7_trans", {31'd0, dmtrans},    32'd0);

        // Load that gets a bus error in the data phase
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h7000_0010, 32'd0, 2'b10, 1'b0, 1'b1, 1'b0);
        nextCycle();
        idleBus(1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0, 1'b1, 1'b1);
        #4;
        checkOutput("t8_rsp", {31'd0, rsp_valid},  32'd1);
        checkOutput("t8_err", {31'd0, rsp_err},    32'd1);
        checkOutput("t8_mis", {31'd0, misaligned}, 32'd0);
        nextCycle();
        idleBus(1'b1);
        #4;
        checkOutput("t8_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("t8_err2",  {31'd0, rsp_err},   32'd0);

        // Reset in the middle of a waited address phase
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h8000_0004, 32'd0, 2'b10, 1'b1, 1'b0, 1'b0);
        nextCycle();
        idleBus(1'b0);
        #2;
        checkOutput("t9_trans_pre", {31'd0, dmtrans}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("t9_trans",  {31'd0, dmtrans},   32'd0);
        checkOutput("t9_stall",  {31'd0, stall},     32'd0);
        checkOutput("t9_rsp",    {31'd0, rsp_valid}, 32'd0);
        checkOutput("t9_ready",  {31'd0, req_ready}, 32'd1);
        checkOutput("t9_lusize", {30'd0, lu_size},   32'd0);
        nextCycle();
        #3;
        checkOutput("t9_rsp_held", {31'd0, rsp_valid}, 32'd0);
        rst_n = 1'b1;

        // Fresh request after reset completes normally
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h9000_0000, 32'd0, 2'b00, 1'b0, 1'b1, 1'b0);
        nextCycle();
        idleBus(1'b1);
        #4;
        checkOutput("t10_c1_trans",  {31'd0, dmtrans}, 32'd1);
        checkOutput("t10_c1_dmaddr", dmaddr,           32'h9000_0000);
        nextCycle();
        #4;
        checkOutput("t10_c2_rsp", {31'd0, rsp_valid}, 32'd1);
        checkOutput("t10_c2_err", {31'd0, rsp_err},   32'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
